fetch_stage: RTL

Front-end stage that feeds the decode stage and, through it, the execute stage. It issues word-aligned instruction-memory reads and realigns the returned data in a halfword buffer. It delivers one complete 16-bit or 32-bit instruction with its PC per cycle. It also handles control-flow redirects and downstream stalls.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_align.sv | 14 +
 rtl/fetch_stage.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: register layout, output bundle and reset constant shared by the fetch stage
package fetch_stage_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state;
  typedef struct packed {
    fetch_state       state;
    logic [31:0]      faddr;
    logic [31:0]      pc;
    logic             skip;
    logic [2:0]       count;
    logic [3:0][15:0] hw_buf;
  } fetch_reg_type;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_out_type;
  function automatic fetch_reg_type init_fetch_reg(input logic [31:0] rv);
    init_fetch_reg = '{state: FETCH, faddr: rv & ~32'd3, pc: rv, skip: rv[1], count: 3'd0, hw_buf: '0};
  endfunction
endpackage

// File: rtl/fetch_align.sv
// fetch_align: decodes the head of the halfword buffer into a complete 16/32-bit instruction
module fetch_align (
  input  logic [3:0][15:0] hw_buf_i,
  input  logic [2:0]       count_i,
  output logic [2:0]       len_o,
  output logic             complete_o,
  output logic [31:0]      instr_o
);
  always_comb begin
    len_o = hw_buf_i[0][1:0] == 2'b11 ? 3'd2 : 3'd1;
    complete_o = count_i >= len_o;
    instr_o = len_o == 3'd2 ? {hw_buf_i[1], hw_buf_i[0]} : {16'h0, hw_buf_i[0]};
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: word fetch into a halfword realignment buffer, one instruction per cycle,
// with redirect and downstream stall handling
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          BUF_HW       = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);
  localparam logic [2:0] FULL = 3'(BUF_HW);
  fetch_reg_type r_q, r_d;
  fetch_out_type fo;
  logic [2:0]  len, pop, cnt;
  logic [31:0] instr;
  logic        complete, room, accept, pending;
  fetch_align u_align (
    .hw_buf_i  (r_q.hw_buf),
    .count_i   (r_q.count),
    .len_o     (len),
    .complete_o(complete),
    .instr_o   (instr)
  );
  always_comb begin
    r_d = r_q;
    fo.valid = complete & ~redirect;
    fo.pc = r_q.pc;
    fo.instr = instr;
    pop = fo.valid & ~stall ? len : 3'd0;
    cnt = r_q.count - pop;
    room = cnt <= FULL - 3'd2;
    imem_valid = rst & (r_q.state == DROP || (r_q.state == FETCH && room));
    accept = imem_valid & imem_ready & (r_q.state != DROP);
    pending = imem_valid & ~imem_ready;
    r_d.hw_buf = pop == 3'd2 ? {r_q.hw_buf[3:2], r_q.hw_buf[3:2]} :
                 pop == 3'd1 ? {r_q.hw_buf[3], r_q.hw_buf[3:1]} : r_q.hw_buf;
    // a skipped word contributes only its upper halfword (redirect into bit 1)
    if (accept && r_q.skip) r_d.hw_buf[cnt[1:0]] = imem_rdata[31:16];
    if (accept && !r_q.skip) begin
      r_d.hw_buf[cnt[1:0]] = imem_rdata[15:0];
      r_d.hw_buf[cnt[1:0] + 2'd1] = imem_rdata[31:16];
    end
    r_d.count = cnt + (accept ? (r_q.skip ? 3'd1 : 3'd2) : 3'd0);
    r_d.skip = accept ? 1'b0 : r_q.skip;
    r_d.faddr = accept ? r_q.faddr + 32'd4 : r_q.faddr;
    r_d.pc = r_q.pc + {28'd0, pop, 1'b0};
    r_d.state = r_q.state == DROP ? (imem_ready ? FETCH : DROP) : (room ? FETCH : HOLD);
    // DROP parks the new target in pc while the old address is still on the bus
    if (r_q.state == DROP && imem_ready) r_d.faddr = r_q.pc & ~32'd3;
    if (redirect) begin
      r_d.count = 3'd0;
      r_d.pc = redirect_addr & ~32'd1;
      r_d.skip = redirect_addr[1];
      r_d.state = pending ? DROP : FETCH;
      r_d.faddr = pending ? r_q.faddr : redirect_addr & ~32'd3;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= init_fetch_reg(RESET_VECTOR);
    else r_q <= r_d;
  assign imem_addr = r_q.faddr;
  assign fetch_valid = fo.valid;
  assign fetch_pc = fo.pc;
  assign fetch_instr = fo.instr;
endmodule
